sdram_arb: RTL and testbench

Three-port arbiter that shares the single SDRAM controller request port between the ROM loader (ioctl download), video fetch and CPU. It sits in `mycore` between the requesters and the SDRAM controller's word port. It contains the ioctl write adapter that drives `ioctl_wait`, so a download throttles itself to SDRAM write throughput. One transaction is in flight at a time. Priority is loader > video > CPU, with a starvation guard for the CPU.

---
 rtl/sdram_arb.sv | 187 ++++++++++++++++++
 tb/tb_sdram_arb.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - three-port SDRAM request arbiter (loader > video > CPU) with ioctl write adapter
`timescale 1ns/1ps
module sdram_arb #(
  parameter int STARVE_MAX = 4,
  parameter int AW         = 25
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [AW-1:0] ioctl_addr,
  input  logic [15:0]   ioctl_dout,
  output logic          ioctl_wait,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [15:0]   vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  input  logic [1:0]    cpu_be,
  output logic          cpu_ack,
  output logic [15:0]   cpu_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [1:0]    mem_be,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata
);

  localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {O_LD, O_VID, O_CPU} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          ld_pend_q, ld_pend_d;
  logic [AW-1:0] ld_addr_q, ld_addr_d;
  logic [15:0]   ld_data_q, ld_data_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]    mem_be_q, mem_be_d;
  logic          vid_ack_q, vid_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [15:0]   vid_rdata_q, vid_rdata_d;
  logic [15:0]   cpu_rdata_q, cpu_rdata_d;

  logic cpu_ok, force_cpu, pick_cpu, pick_vid;

  // CPU is locked out for the whole download session; the starvation guard only reorders CPU vs video.
  assign cpu_ok    = cpu_req && !ioctl_download;
  assign force_cpu = cpu_ok && (starve_q == STARVE_LIM);
  assign pick_cpu  = !ld_pend_q && (force_cpu || (!vid_req && cpu_ok));
  assign pick_vid  = !ld_pend_q && !force_cpu && vid_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ld_pend_d   = ld_pend_q;
    ld_addr_d   = ld_addr_q;
    ld_data_d   = ld_data_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    vid_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_rdata_d = vid_rdata_q;
    cpu_rdata_d = cpu_rdata_q;

    if (ioctl_wr && !ld_pend_q) begin
      ld_pend_d = 1'b1;
      ld_addr_d = ioctl_addr;
      ld_data_d = ioctl_dout;
    end

    case (state_q)
      S_IDLE: begin
        if (!cpu_req) starve_d = '0;
        if (ld_pend_q) begin
          state_d     = S_BUSY;
          owner_d     = O_LD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ld_addr_q;
          mem_wdata_d = ld_data_q;
          mem_be_d    = 2'b11;
        end else if (pick_cpu) begin
          state_d     = S_BUSY;
          owner_d     = O_CPU;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          mem_be_d    = cpu_be;
          starve_d    = '0;
        end else if (pick_vid) begin
          state_d     = S_BUSY;
          owner_d     = O_VID;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = vid_addr;
          mem_wdata_d = '0;
          mem_be_d    = 2'b11;
          if (cpu_req && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          case (owner_q)
            O_LD:    ld_pend_d = 1'b0;
            O_VID: begin
              vid_ack_d   = 1'b1;
              vid_rdata_d = mem_rdata;
            end
            O_CPU: begin
              cpu_ack_d   = 1'b1;
              cpu_rdata_d = mem_rdata;
            end
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      owner_q     <= O_LD;
      ld_pend_q   <= 1'b0;
      ld_addr_q   <= '0;
      ld_data_q   <= '0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ld_pend_q   <= ld_pend_d;
      ld_addr_q   <= ld_addr_d;
      ld_data_q   <= ld_data_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      vid_ack_q   <= vid_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_rdata_q <= vid_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign ioctl_wait = ld_pend_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign vid_ack    = vid_ack_q;
  assign vid_rdata  = vid_rdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: tb/tb_sdram_arb.sv
// tb/tb_sdram_arb.sv - self-checking bench for sdram_arb: transaction model, memory responder, directed tests
`timescale 1ns/1ps
module tb_sdram_arb;
  localparam int AW   = 25;
  localparam int SMAX = 4;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic          reset_n;
  logic          ioctl_download, ioctl_wr, ioctl_wait;
  logic [AW-1:0] ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic          vid_req, vid_ack;
  logic [AW-1:0] vid_addr;
  logic [15:0]   vid_rdata;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata, cpu_rdata;
  logic [1:0]    cpu_be;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata;
  logic [1:0]    mem_be;

  sdram_arb #(.STARVE_MAX(SMAX), .AW(AW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Memory controller stand-in: acks after lat cycles of mem_req, word store keyed by address
  logic [15:0] mem [int];
  int lat  = 2;
  int rcnt = 0;
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'hFFFF;
    forever begin
      @(posedge clk_sys);
      #1;
      if (!reset_n || mem_ack) begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hFFFF;
        rcnt      = 0;
      end else if (mem_req) begin
        rcnt++;
        if (rcnt >= lat) begin
          mem_ack = 1'b1;
          if (mem_we) mem[int'(mem_addr)] = mem_wdata;
          else mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 16'hDEAD;
        end
      end
    end
  end

  typedef struct {
    byte           who;
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [1:0]    be;
  } grant_t;
  grant_t glog[$];

  // Transaction-level model: who owns the bus, what the loader holds, how long the CPU has waited
  bit            m_busy, m_ld_pend, m_tx_we, e_vid_ack, e_cpu_ack, e_cpu_rd, prev_req;
  int            m_owner, m_streak;
  logic [AW-1:0] m_ld_addr, m_tx_addr;
  logic [15:0]   m_ld_data, m_tx_wdata, e_vid_rdata, e_cpu_rdata;
  logic [1:0]    m_tx_be;

  function automatic int pick(bit ldp, bit vr, bit cr, bit dl, int streak);
    if (ldp) return 1;
    if (cr && !dl && streak == SMAX) return 3;
    if (vr) return 2;
    if (cr && !dl) return 3;
    return 0;
  endfunction

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_ioctl_wait", ioctl_wait, 0);
      check("rst_vid_ack", vid_ack, 0);
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_mem_fields", {mem_we, mem_be, mem_wdata}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rdata", {vid_rdata, cpu_rdata}, 0);
      m_busy = 0; m_ld_pend = 0; m_streak = 0; m_owner = 0;
      e_vid_ack = 0; e_cpu_ack = 0; prev_req = 0;
    end else begin
      check("mem_req", mem_req, m_busy);
      check("ioctl_wait", ioctl_wait, m_ld_pend);
      check("vid_ack", vid_ack, e_vid_ack);
      check("cpu_ack", cpu_ack, e_cpu_ack);
      if (m_busy) begin
        check("mem_we", mem_we, m_tx_we);
        check("mem_addr", mem_addr, m_tx_addr);
        if (m_tx_we) begin
          check("mem_wdata", mem_wdata, m_tx_wdata);
          check("mem_be", mem_be, m_tx_be);
        end
      end
      if (e_vid_ack) check("vid_rdata", vid_rdata, e_vid_rdata);
      if (e_cpu_ack && e_cpu_rd) check("cpu_rdata", cpu_rdata, e_cpu_rdata);
      if (mem_req && !prev_req)
        glog.push_back('{who: (mem_addr >= 'h2000) ? "C" : (mem_addr >= 'h1000) ? "V" : "L",
                         we: mem_we, addr: mem_addr, wdata: mem_wdata, be: mem_be});
      prev_req = mem_req;

      e_vid_ack = 0;
      e_cpu_ack = 0;
      begin
        bit accept;
        int w;
        accept = ioctl_wr && !m_ld_pend;
        if (m_busy) begin
          if (mem_ack) begin
            m_busy = 0;
            if (m_owner == 1) m_ld_pend = 0;
            if (m_owner == 2) begin e_vid_ack = 1; e_vid_rdata = mem_rdata; end
            if (m_owner == 3) begin e_cpu_ack = 1; e_cpu_rd = !m_tx_we; e_cpu_rdata = mem_rdata; end
          end
        end else begin
          w = pick(m_ld_pend, vid_req, cpu_req, ioctl_download, m_streak);
          if (!cpu_req) m_streak = 0;
          if (w == 1) begin m_tx_we = 1; m_tx_addr = m_ld_addr; m_tx_wdata = m_ld_data; m_tx_be = 2'b11; end
          if (w == 2) begin
            m_tx_we = 0; m_tx_addr = vid_addr;
            if (cpu_req && m_streak < SMAX) m_streak++;
          end
          if (w == 3) begin
            m_tx_we = cpu_we; m_tx_addr = cpu_addr; m_tx_wdata = cpu_wdata; m_tx_be = cpu_be;
            m_streak = 0;
          end
          if (w != 0) begin m_busy = 1; m_owner = w; end
        end
        if (accept) begin m_ld_pend = 1; m_ld_addr = ioctl_addr; m_ld_data = ioctl_dout; end
      end
    end
  end

  task automatic ld_write(input logic [AW-1:0] a, input logic [15:0] d);
    int n = 0;
    while (ioctl_wait && n < 50) begin step(); n++; end
    check("ld_wait_free", ioctl_wait, 0);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 200) begin
      step(); n++;
      if (!mem_req && !ioctl_wait && !vid_ack && !cpu_ack) quiet++;
      else quiet = 0;
    end
    check(name, quiet, 3);
  endtask

  logic [15:0] dl_data [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    int s, s2;
    bit got_v, got_c, v_first;
    logic [15:0] vr, cr;
    string seq;
    bit saw_cpu;

    reset_n = 0; ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0; ioctl_dout = '0;
    vid_req = 0; vid_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("init_mem_req", mem_req, 0);
    check("init_ioctl_wait", ioctl_wait, 0);
    #2 reset_n = 1;
    step();

    // Download 4 words
    ioctl_download = 1;
    s = glog.size();
    for (int i = 0; i < 4; i++) ld_write(AW'(2 * i), dl_data[i]);
    wait_idle("dl_idle");
    ioctl_download = 0;
    check("dl_count", glog.size() - s, 4);
    if (glog.size() >= s + 4)
      for (int i = 0; i < 4; i++) begin
        check("dl_wdata", glog[s+i].wdata, dl_data[i]);
        check("dl_addr", glog[s+i].addr, 2 * i);
        check("dl_we_be", {glog[s+i].we, glog[s+i].be}, 3'b111);
      end

    // Video and CPU read requested together
    mem[32'h1000] = 16'hABCD;
    mem[32'h2000] = 16'h1234;
    vid_req = 1; vid_addr = 'h1000;
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h2000; cpu_be = 2'b11;
    got_v = 0; got_c = 0; v_first = 0; vr = '0; cr = '0;
    for (int c = 0; c < 100 && !(got_v && got_c); c++) begin
      step();
      if (vid_ack) begin got_v = 1; vr = vid_rdata; vid_req = 0; v_first = !got_c; end
      if (cpu_ack) begin got_c = 1; cr = cpu_rdata; cpu_req = 0; end
    end
    check("vc_vid_done", got_v, 1);
    check("vc_cpu_done", got_c, 1);
    check("vc_vid_first", v_first, 1);
    check("vc_vid_rdata", vr, 16'hABCD);
    check("vc_cpu_rdata", cr, 16'h1234);
    wait_idle("vc_idle");

    // Starvation guard with both held
    s = glog.size();
    vid_req = 1; vid_addr = 'h1008;
    cpu_req = 1; cpu_we = 1; cpu_addr = 'h2008; cpu_wdata = 16'h5A5A; cpu_be = 2'b01;
    for (int c = 0; c < 300 && glog.size() < s + 10; c++) step();
    vid_req = 0; cpu_req = 0;
    wait_idle("st_idle");
    check("st_count", (glog.size() >= s + 10), 1);
    if (glog.size() >= s + 10) begin
      seq = "";
      for (int i = 0; i < 10; i++) seq = $sformatf("%s%c", seq, glog[s+i].who);
      check_str("st_sequence", seq, "VVVVCVVVVC");
    end

    // CPU lockout during download
    mem[32'h200A] = 16'h4C4C;
    ioctl_download = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 'h200A; cpu_be = 2'b11;
    s = glog.size();
    ld_write('h10, 16'hC001);
    ld_write('h12, 16'hC002);
    ld_write('h14, 16'hC003);
    wait_idle("lo_idle");
    saw_cpu = 0;
    for (int i = s; i < glog.size(); i++) if (glog[i].who == "C") saw_cpu = 1;
    check("lo_no_cpu", saw_cpu, 0);
    check("lo_ld_count", glog.size() - s, 3);
    s2 = glog.size();
    ioctl_download = 0;
    got_c = 0; cr = '0;
    for (int c = 0; c < 50 && !got_c; c++) begin
      step();
      if (cpu_ack) begin got_c = 1; cr = cpu_rdata; cpu_req = 0; end
    end
    check("lo_cpu_done", got_c, 1);
    check("lo_cpu_rdata", cr, 16'h4C4C);
    if (glog.size() > s2) check("lo_first_after", glog[s2].who, "C");
    wait_idle("lo_idle2");

    // Dropped strobe while ioctl_wait is high
    lat = 3;
    ioctl_download = 1;
    s = glog.size();
    ld_write('h20, 16'hAAAA);
    check("dr_wait_high", ioctl_wait, 1);
    ioctl_wr = 1; ioctl_addr = 'h22; ioctl_dout = 16'hBBBB;
    step();
    ioctl_wr = 0;
    wait_idle("dr_idle");
    ioctl_download = 0;
    check("dr_count", glog.size() - s, 1);
    if (glog.size() > s) check("dr_wdata", glog[s].wdata, 16'hAAAA);
    check("dr_second_absent", mem.exists(32'h22), 0);

    // Reset in the middle of a video transaction
    lat = 5;
    vid_req = 1; vid_addr = 'h100C;
    for (int c = 0; c < 20 && !mem_req; c++) step();
    check("mr_busy", mem_req, 1);
    #2 reset_n = 0;
    #1;
    check("mr_req_dropped", mem_req, 0);
    check("mr_acks", {vid_ack, cpu_ack}, 0);
    vid_req = 0;
    step();
    step();
    #2 reset_n = 1;
    step();
    lat = 2;
    mem[32'h100E] = 16'h7777;
    vid_req = 1; vid_addr = 'h100E;
    got_v = 0; vr = '0;
    for (int c = 0; c < 50 && !got_v; c++) begin
      step();
      if (vid_ack) begin got_v = 1; vr = vid_rdata; vid_req = 0; end
    end
    check("mr_vid_done", got_v, 1);
    check("mr_vid_rdata", vr, 16'h7777);
    wait_idle("mr_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
